trap_ctrl: RTL and testbench

Trap sequencer and CSR-port arbiter for the machine-mode CSR register file.
- Owns the file's single address/write port.
- When idle, passes the pipeline's csrrw/csrrwi accesses straight through.
- On ecall/ebreak/illegal-instruction traps and on mret, stalls the pipeline and runs a fixed multi-cycle sequence: save or restore mepc/mcause/mstatus, then redirect the PC.
- Sits between decode/execute control and the CSR block.

---
 rtl/trap_pkg.sv | 46 ++++
 rtl/trap_ctrl.sv | 115 +++++++++++
 tb/tb_trap_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared CSR addresses, mstatus bit positions, trap cause codes and sequencer states for trap_ctrl.
// The mstatus helpers act on the low byte only, so they work for any XLEN.
package trap_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h000;
    localparam logic [11:0] ADDR_MEPC    = 12'h041;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h042;
    localparam logic [11:0] ADDR_MTVEC   = 12'h005;
    localparam logic [11:0] ADDR_MIP     = 12'h044;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    localparam int CAUSE_ILLEGAL = 2;
    localparam int CAUSE_EBREAK  = 3;
    localparam int CAUSE_ECALL   = 11;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_STATUS,
        T_VEC,
        R_STATUS,
        R_EPC
    } state_t;

    // Trap entry: stash MIE into MPIE and mask interrupts.
    function automatic logic [7:0] mstatus_trap_lo(input logic [7:0] old);
        logic [7:0] v;
        v           = old;
        v[MPIE_BIT] = old[MIE_BIT];
        v[MIE_BIT]  = 1'b0;
        return v;
    endfunction

    // Trap return: restore MIE from MPIE and re-arm MPIE.
    function automatic logic [7:0] mstatus_mret_lo(input logic [7:0] old);
        logic [7:0] v;
        v           = old;
        v[MIE_BIT]  = old[MPIE_BIT];
        v[MPIE_BIT] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer owning the CSR file port; pass-through when idle, redirect at +4 (trap) / +2 (mret).
// Backpressure: stall is raised combinationally on a request and held until the sequence returns to IDLE.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trap_req,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic               mret_req,
    input  logic               ins_csr_w,
    input  logic [11:0]        ins_csr_addr,
    input  logic [XLEN-1:0]    ins_csr_wdata,
    output logic [XLEN-1:0]    ins_csr_rdata,
    output logic               csr_w,
    output logic [11:0]        csr_addr,
    output logic [XLEN-1:0]    csr_wdata,
    input  logic [XLEN-1:0]    csr_rdata,
    output logic               stall,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    pc_target,
    output logic               busy
);

    state_t             state;
    state_t             state_nxt;
    logic [XLEN-1:0]    pc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    pc_target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= '0;
            cause_q     <= '0;
            pc_target_q <= '0;
        end else begin
            state       <= state_nxt;
            pc_target_q <= pc_target;
            if (state == IDLE && trap_req) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        csr_w       = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        stall       = 1'b1;
        pc_redirect = 1'b0;
        pc_target   = pc_target_q;
        case (state)
            IDLE: begin
                stall     = trap_req | mret_req;
                // The instruction raising the trap or mret must not commit its own CSR write.
                csr_w     = ins_csr_w & ~(trap_req | mret_req);
                csr_addr  = ins_csr_addr;
                csr_wdata = ins_csr_wdata;
                if (trap_req) begin
                    state_nxt = T_EPC;
                end else if (mret_req) begin
                    state_nxt = R_STATUS;
                end
            end
            T_EPC: begin
                csr_w     = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_wdata = pc_q;
                state_nxt = T_CAUSE;
            end
            T_CAUSE: begin
                csr_w     = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
                state_nxt = T_STATUS;
            end
            T_STATUS: begin
                csr_w     = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = {csr_rdata[XLEN-1:8], mstatus_trap_lo(csr_rdata[7:0])};
                state_nxt = T_VEC;
            end
            T_VEC: begin
                csr_addr    = ADDR_MTVEC;
                pc_redirect = 1'b1;
                pc_target   = {csr_rdata[XLEN-1:2], 2'b00};
                state_nxt   = IDLE;
            end
            R_STATUS: begin
                csr_w     = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = {csr_rdata[XLEN-1:8], mstatus_mret_lo(csr_rdata[7:0])};
                state_nxt = R_EPC;
            end
            R_EPC: begin
                csr_addr    = ADDR_MEPC;
                pc_redirect = 1'b1;
                pc_target   = csr_rdata;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign ins_csr_rdata = csr_rdata;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: CSR file environment, cycle-level expectation model and directed trap/mret scenarios.
module tb_trap_ctrl;

    localparam int XLEN    = 32;
    localparam int CAUSE_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trap_req;
    logic [CAUSE_W-1:0] trap_cause;
    logic [XLEN-1:0]   trap_pc;
    logic              mret_req;
    logic              ins_csr_w;
    logic [11:0]       ins_csr_addr;
    logic [XLEN-1:0]   ins_csr_wdata;
    logic [XLEN-1:0]   ins_csr_rdata;
    logic              csr_w;
    logic [11:0]       csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;
    logic              stall;
    logic              pc_redirect;
    logic [XLEN-1:0]   pc_target;
    logic              busy;

    trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req),
        .ins_csr_w(ins_csr_w), .ins_csr_addr(ins_csr_addr), .ins_csr_wdata(ins_csr_wdata),
        .ins_csr_rdata(ins_csr_rdata),
        .csr_w(csr_w), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit run_cmp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR file the DUT drives: combinational read, write on the clock edge.
    logic [31:0] csr_file [0:4095];
    assign csr_rdata = csr_file[csr_addr];
    always @(posedge clk) if (csr_w) csr_file[csr_addr] <= csr_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expectation model: a countdown of remaining busy cycles plus its own CSR image.
    logic [31:0] mcsr [0:4095];
    int          seq_left = 0;
    bit          seq_trap = 0;
    logic [31:0] m_pc = '0;
    logic [3:0]  m_cause = '0;
    logic [31:0] tgt_hold = '0;

    function automatic logic [31:0] st_trap(input logic [31:0] old);
        return (old & ~32'h88) | ((old & 32'h8) << 4);
    endfunction
    function automatic logic [31:0] st_mret(input logic [31:0] old);
        return (old & ~32'h88) | ((old & 32'h80) >> 4) | 32'h80;
    endfunction
    function automatic logic [31:0] redir_tgt();
        return seq_trap ? (mcsr[12'h005] & ~32'h3) : mcsr[12'h041];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_left = 0;
            tgt_hold = '0;
        end else if (seq_left > 0) begin
            if (seq_left == 1) tgt_hold = redir_tgt();
            if (seq_trap) begin
                if (seq_left == 4)      mcsr[12'h041] = m_pc;
                else if (seq_left == 3) mcsr[12'h042] = {28'b0, m_cause};
                else if (seq_left == 2) mcsr[12'h000] = st_trap(mcsr[12'h000]);
            end else if (seq_left == 2) begin
                mcsr[12'h000] = st_mret(mcsr[12'h000]);
            end
            seq_left = seq_left - 1;
        end else if (trap_req) begin
            seq_trap = 1;
            seq_left = 4;
            m_pc     = trap_pc;
            m_cause  = trap_cause;
        end else if (mret_req) begin
            seq_trap = 0;
            seq_left = 2;
        end else if (ins_csr_w) begin
            mcsr[ins_csr_addr] = ins_csr_wdata;
        end
    end

    logic [11:0] watch [5] = '{12'h000, 12'h005, 12'h041, 12'h042, 12'h044};
    logic        e_busy, e_red, e_w;
    logic [11:0] e_addr;

    always @(negedge clk) begin
        if (run_cmp) begin
            e_busy = (seq_left > 0);
            e_red  = (seq_left == 1);
            e_w    = 1'b0;
            e_addr = ins_csr_addr;
            if (!e_busy) begin
                e_w = ins_csr_w && !trap_req && !mret_req;
            end else if (seq_trap) begin
                e_w = (seq_left >= 2);
                case (seq_left)
                    4:       e_addr = 12'h041;
                    3:       e_addr = 12'h042;
                    2:       e_addr = 12'h000;
                    default: e_addr = 12'h005;
                endcase
            end else begin
                e_w    = (seq_left == 2);
                e_addr = (seq_left == 2) ? 12'h000 : 12'h041;
            end
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_stall", 32'(stall), 32'(e_busy || trap_req || mret_req));
            chk("cyc_redirect", 32'(pc_redirect), 32'(e_red));
            chk("cyc_target", pc_target, e_red ? redir_tgt() : tgt_hold);
            chk("cyc_csr_w", 32'(csr_w), 32'(e_w));
            if (e_busy || e_w) chk("cyc_csr_addr", 32'(csr_addr), 32'(e_addr));
            chk("cyc_rdata_pass", ins_csr_rdata, csr_rdata);
            for (int i = 0; i < 5; i++) chk("cyc_csr_image", csr_file[watch[i]], mcsr[watch[i]]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        ins_csr_w     = 1'b1;
        ins_csr_addr  = a;
        ins_csr_wdata = d;
        step();
        ins_csr_w = 1'b0;
    endtask

    // Called at +1 of a cycle; raises the request, holds it through the redirect, drops it after.
    task automatic run_seq(input bit t, input bit m, input logic [3:0] c, input logic [31:0] pc,
                           output int lat, output logic [31:0] tgt, output int stalls);
        int start;
        bit seen;
        lat = -1; tgt = '0; stalls = 0; seen = 0;
        trap_req = t; mret_req = m; trap_cause = c; trap_pc = pc;
        start = cyc;
        for (int i = 0; i < 12 && !seen; i++) begin
            #2;
            if (stall) stalls++;
            if (pc_redirect) begin
                seen = 1;
                lat  = cyc - start;
                tgt  = pc_target;
            end
            step();
        end
        trap_req = 0; mret_req = 0; ins_csr_w = 0;
        if (!seen) chk("redirect_timeout", 32'd0, 32'd1);
        step();
    endtask

    int          lat, stalls;
    logic [31:0] tgt;

    initial begin
        trap_req = 0; mret_req = 0; trap_cause = '0; trap_pc = '0;
        ins_csr_w = 0; ins_csr_addr = '0; ins_csr_wdata = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_redirect", 32'(pc_redirect), 32'd0);
        chk("reset_target", pc_target, 32'h0);
        rst_n = 1;
        step();
        csr_wr(12'h000, 32'h8);
        csr_wr(12'h005, 32'h103);
        csr_wr(12'h041, 32'h0);
        csr_wr(12'h042, 32'h0);
        csr_wr(12'h044, 32'h0);
        run_cmp = 1;

        // Pass-through write in IDLE
        ins_csr_w = 1; ins_csr_addr = 12'h042; ins_csr_wdata = 32'h5;
        #2;
        chk("pass_stall", 32'(stall), 32'd0);
        chk("pass_rdata", ins_csr_rdata, csr_file[12'h042]);
        step();
        ins_csr_w = 0;
        chk("pass_mcause", csr_file[12'h042], 32'h5);

        // ecall
        run_seq(1, 0, 4'd11, 32'h40, lat, tgt, stalls);
        chk("ecall_latency", 32'(lat), 32'd4);
        chk("ecall_target", tgt, 32'h100);
        chk("ecall_stall_cycles", 32'(stalls), 32'd5);
        chk("ecall_mepc", csr_file[12'h041], 32'h40);
        chk("ecall_mcause", csr_file[12'h042], 32'd11);
        chk("ecall_mstatus", csr_file[12'h000], 32'h80);

        // mret
        run_seq(0, 1, 4'd0, 32'h0, lat, tgt, stalls);
        chk("mret_latency", 32'(lat), 32'd2);
        chk("mret_target", tgt, 32'h40);
        chk("mret_stall_cycles", 32'(stalls), 32'd3);
        chk("mret_mstatus", csr_file[12'h000], 32'h88);

        // Trap collides with a pipeline write to mtvec
        ins_csr_w = 1; ins_csr_addr = 12'h005; ins_csr_wdata = 32'hDEAD;
        run_seq(1, 0, 4'd3, 32'h80, lat, tgt, stalls);
        chk("arb_mtvec", csr_file[12'h005], 32'h103);
        chk("arb_latency", 32'(lat), 32'd4);
        chk("arb_mepc", csr_file[12'h041], 32'h80);
        chk("arb_mcause", csr_file[12'h042], 32'd3);
        chk("arb_mstatus", csr_file[12'h000], 32'h80);

        // trap and mret together: trap wins
        run_seq(1, 1, 4'd2, 32'hC4, lat, tgt, stalls);
        chk("prec_latency", 32'(lat), 32'd4);
        chk("prec_stall_cycles", 32'(stalls), 32'd5);
        chk("prec_mepc", csr_file[12'h041], 32'hC4);
        chk("prec_mcause", csr_file[12'h042], 32'd2);
        chk("prec_mstatus", csr_file[12'h000], 32'h0);

        // Reset while in T_CAUSE
        trap_req = 1; trap_cause = 4'd11; trap_pc = 32'h1F0;
        step();
        step();
        #2;
        rst_n = 0; trap_req = 0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_redirect", 32'(pc_redirect), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        step();
        chk("rst_mid_mepc", csr_file[12'h041], 32'h1F0);
        chk("rst_mid_mcause", csr_file[12'h042], 32'd2);
        #2;
        rst_n = 1;
        step();

        // Back in IDLE: a fresh trap runs normally
        run_seq(1, 0, 4'd3, 32'h300, lat, tgt, stalls);
        chk("post_latency", 32'(lat), 32'd4);
        chk("post_target", tgt, 32'h100);
        chk("post_mepc", csr_file[12'h041], 32'h300);
        chk("post_mcause", csr_file[12'h042], 32'd3);
        chk("post_mip", csr_file[12'h044], 32'h0);

        repeat (3) step();
        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
